// File: rtl/nor_wide_qual.sv
// -----------------------------------------------------------------------------
// nor_wide_qual
//
// Parametrised wide NOR with per-bit mask, registered output and a
// consecutive-sample qualification counter. Intended as a deglitched
// all-zero / idle detector on status buses: ZNQ only asserts once the NOR
// has been true for QUAL consecutive enabled samples, and STICKY latches
// every ZNQ rising event until software clears it.
//
// Parameters:
//   WIDTH  number of NOR inputs (>= 2)
//   QUAL   consecutive enabled true samples required for ZNQ (>= 1)
//   CW     derived width of CNT, $clog2(QUAL+1) (not overridable)
//
// Ports:
//   CLK     in   1      rising-edge clock
//   RN      in   1      synchronous active-low reset (priority over EN, CLR)
//   A       in   WIDTH  NOR data inputs
//   MASK    in   WIDTH  1 = corresponding A bit ignored (forced to 0)
//   EN      in   1      sample enable; 0 = ZN/ZNQ/CNT hold
//   CLR     in   1      synchronous clear of STICKY only
//   ZN      out  1      registered NOR of unmasked inputs
//   ZNQ     out  1      qualified NOR
//   STICKY  out  1      latched ZNQ-rise event
//   CNT     out  CW     current qualification count
//
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module nor_wide_qual #(
  parameter  int WIDTH = 4,
  parameter  int QUAL  = 3,
  localparam int CW    = $clog2(QUAL + 1)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] MASK,
  input  logic             EN,
  input  logic             CLR,
  output logic             ZN,
  output logic             ZNQ,
  output logic             STICKY,
  output logic [CW-1:0]    CNT
);

  localparam logic [CW-1:0] QUAL_C = CW'(QUAL);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  // Qualification state is encoded purely by the count; this enum is a
  // decoded view that keeps the next-count logic readable.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNT     = 2'd1,
    ST_QUALIFIED = 2'd2
  } state_e;

  logic          r_zn;
  logic          r_znq;
  logic          r_sticky;
  logic [CW-1:0] r_cnt;

  logic          w_raw;
  state_e        w_state;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_qual_nxt;
  logic          w_set;

  // Masked bits are ANDed with 0 before the reduction, so an X on a masked
  // input cannot reach w_raw. All bits masked yields raw = 1.
  assign w_raw = ~|(A & ~MASK);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    w_state = ST_IDLE;
    if (r_cnt == QUAL_C) begin
      w_state = ST_QUALIFIED;
    end else if (r_cnt != '0) begin
      w_state = ST_COUNT;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (EN) begin
      if (!w_raw) begin
        w_cnt_nxt = '0;
      end else begin
        unique case (w_state)
          // With QUAL=1 this step lands directly on QUALIFIED.
          ST_IDLE:      w_cnt_nxt = ONE_C;
          ST_COUNT:     w_cnt_nxt = r_cnt + ONE_C;
          ST_QUALIFIED: w_cnt_nxt = QUAL_C;
          default:      w_cnt_nxt = '0;
        endcase
      end
    end
  end

  assign w_qual_nxt = (w_cnt_nxt == QUAL_C);

  // A ZNQ rising edge: this enabled true sample completes qualification
  // and ZNQ is currently low.
  assign w_set = EN & w_raw & w_qual_nxt & ~r_znq;

  always_ff @(posedge CLK) begin
    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!RN) begin
      r_zn     <= 1'b0;
      r_znq    <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (EN) begin
        r_zn  <= w_raw;
        r_znq <= w_qual_nxt;
        r_cnt <= w_cnt_nxt;
      end
      // CLR is honoured regardless of EN; a coincident set wins so no
      // qualification event is lost.
      r_sticky <= w_set | (r_sticky & ~CLR);
    end
  end

  assign ZN     = r_zn;
  assign ZNQ    = r_znq;
  assign STICKY = r_sticky;
  assign CNT    = r_cnt;

endmodule

// File: tb/tb_nor_wide_qual.sv
// -----------------------------------------------------------------------------
// tb_nor_wide_qual
//
// Scoreboard bench for nor_wide_qual. Two instances share one clock:
//   u_dut0  WIDTH=4, QUAL=3  directed vectors with hand-computed results
//   u_dut1  WIDTH=8, QUAL=1  random A/CLR with a small reference model
// The driver pushes the expected post-edge outputs into a queue before each
// edge; an independent monitor pops one entry #1 after every rising edge and
// compares it with the selected instance.
// -----------------------------------------------------------------------------
module tb_nor_wide_qual;

  logic       clk;
  logic       rn0, en0, clr0;
  logic [3:0] a0, m0;
  logic       zn0, znq0, st0;
  logic [1:0] cnt0;

  logic       rn1, en1, clr1;
  logic [7:0] a1, m1;
  logic       zn1, znq1, st1;
  logic [0:0] cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int    sel;
    logic  zn;
    logic  znq;
    logic  st;
    int    cnt;
    string tag;
  } exp_t;

  exp_t sb_q[$];

  nor_wide_qual #(.WIDTH(4), .QUAL(3)) u_dut0 (
    .CLK(clk), .RN(rn0), .A(a0), .MASK(m0), .EN(en0), .CLR(clr0),
    .ZN(zn0), .ZNQ(znq0), .STICKY(st0), .CNT(cnt0)
  );

  nor_wide_qual #(.WIDTH(8), .QUAL(1)) u_dut1 (
    .CLK(clk), .RN(rn1), .A(a1), .MASK(m1), .EN(en1), .CLR(clr1),
    .ZN(zn1), .ZNQ(znq1), .STICKY(st1), .CNT(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%0h expected=%0h", tag, field, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge that the driver described.
  initial begin
    exp_t e;
    logic zn_a, znq_a, st_a, xs;
    logic [31:0] cnt_a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.sel == 0) begin
          zn_a = zn0; znq_a = znq0; st_a = st0; cnt_a = 32'(cnt0);
          xs = $isunknown({zn0, znq0, st0, cnt0});
        end else begin
          zn_a = zn1; znq_a = znq1; st_a = st1; cnt_a = 32'(cnt1);
          xs = $isunknown({zn1, znq1, st1, cnt1});
        end
        check(e.tag, "ZN",     32'(zn_a),  32'(e.zn));
        check(e.tag, "ZNQ",    32'(znq_a), 32'(e.znq));
        check(e.tag, "STICKY", 32'(st_a),  32'(e.st));
        check(e.tag, "CNT",    cnt_a,      32'(e.cnt));
        check(e.tag, "no_x",   32'(xs),    32'd0);
      end
    end
  end

  // Drive one edge on u_dut0 and post its expected outputs after that edge.
  task automatic step0(input logic rn, input logic [3:0] a, input logic [3:0] m,
                       input logic en, input logic clr,
                       input logic ezn, input logic eznq, input logic est,
                       input int ecnt, input string tag);
    exp_t e;
    @(negedge clk);
    rn0 = rn; a0 = a; m0 = m; en0 = en; clr0 = clr;
    e.sel = 0; e.zn = ezn; e.znq = eznq; e.st = est; e.cnt = ecnt; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic step1(input logic rn, input logic [7:0] a, input logic [7:0] m,
                       input logic clr,
                       input logic ezn, input logic eznq, input logic est,
                       input int ecnt, input string tag);
    exp_t e;
    @(negedge clk);
    rn1 = rn; a1 = a; m1 = m; en1 = 1'b1; clr1 = clr;
    e.sel = 1; e.zn = ezn; e.znq = eznq; e.st = est; e.cnt = ecnt; e.tag = tag;
    sb_q.push_back(e);
  endtask

  initial begin
    logic       raw, prev_znq, st_m, clr;
    logic [7:0] a;

    rn0 = 1'b0; a0 = '0; m0 = '0; en0 = 1'b1; clr0 = 1'b0;
    rn1 = 1'b0; a1 = '0; m1 = '0; en1 = 1'b1; clr1 = 1'b0;

    //     rn    A        MASK     en    clr   zn znq st cnt
    // Reset held for two edges, then qualification from idle.
    step0(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 0, 0, 0, 0, "rst_e1");
    step0(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 0, 0, 0, 0, "rst_e2");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 1, "run_e1");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 2, "run_e2");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 1, 1, 3, "run_e3");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 1, 1, 3, "run_sat");

    // Glitch reject: a single true->false->true blip restarts the count.
    step0(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 0, 0, 0, 0, "gl_rst");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 1, "gl_1");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 2, "gl_2");
    step0(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 0, 0, 0, 0, "gl_blip");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 1, "gl_3");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 2, "gl_4");

    // Reset mid-run (CNT=2) discards the count, even with EN=0 and CLR=1.
    step0(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 0, 0, 0, 0, "en_rst");
    // Enable gating: EN 1,0,0,1,1.
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 1, "en_1");
    step0(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 0, 0, 1, "en_0a");
    step0(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 0, 0, 1, "en_0b");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 2, "en_2");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 1, 1, 3, "en_3");
    // Disabled false input: everything holds.
    step0(1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 1, 1, 1, 3, "hold_a");
    step0(1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 1, 1, 1, 3, "hold_b");

    // Mask: unmasked false drops the run; masking the set bits restores raw.
    step0(1'b1, 4'b0110, 4'b0000, 1'b1, 1'b0, 0, 0, 1, 0, "mk_off");
    step0(1'b1, 4'b0110, 4'b0110, 1'b1, 1'b0, 1, 0, 1, 1, "mk_on");
    step0(1'b1, 4'bxxxx, 4'b1111, 1'b1, 1'b0, 1, 0, 1, 2, "mk_allx");
    step0(1'b1, 4'bxxxx, 4'b1111, 1'b1, 1'b0, 1, 1, 1, 3, "mk_allx_q");

    // Sticky: CLR alone in QUALIFIED clears it without touching the rest.
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1, 1, 0, 3, "sk_clr0");
    step0(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 0, 0, 0, 0, "sk_drop");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 1, "sk_1");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 2, "sk_2");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1, 1, 1, 3, "sk_setwins");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1, 1, 0, 3, "sk_clr");
    // Sticky set again is cleared by CLR with EN=0.
    step0(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 0, 0, 0, 0, "sk2_drop");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 1, "sk2_1");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 0, 0, 2, "sk2_2");
    step0(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1, 1, 1, 3, "sk2_3");
    step0(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 1, 1, 0, 3, "sk2_clr_dis");
    // Reset has priority over EN and CLR.
    step0(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 0, 0, 0, 0, "fin_rst");

    @(negedge clk);
    en0 = 1'b0;

    // QUAL=1, WIDTH=8: ZNQ follows ZN, CNT in {0,1}, STICKY on each rise.
    step1(1'b0, 8'h00, 8'h00, 1'b0, 0, 0, 0, 0, "q1_rst");
    prev_znq = 1'b0;
    st_m     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      a   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      clr = ($urandom_range(0, 3) == 0);
      raw = (a == 8'h00);
      st_m = (raw & ~prev_znq) | (st_m & ~clr);
      step1(1'b1, a, 8'h00, clr, raw, raw, st_m, int'(raw),
            $sformatf("q1_%0d", i));
      prev_znq = raw;
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
